// File: rtl/fb_line_reader.sv
// fb_line_reader: raster-order framebuffer readback over call/done, FIFO-buffered valid/ready pixel stream; ports CLOCK/RESET, iStart/oBusy, oCall/oAddr/iDone/iData, oPixData/oPixValid/iPixReady, oFrameDone; FB_READER_LOOP_EN enables continuous frames
module fb_line_reader #(
  parameter int H_PIXELS   = 320,
  parameter int V_LINES    = 240,
  parameter int CX_W       = 9,
  parameter int CY_W       = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 iStart,
  output logic                 oBusy,
  output logic                 oCall,
  output logic [CX_W+CY_W-1:0] oAddr,
  input  logic                 iDone,
  input  logic [15:0]          iData,
  output logic [15:0]          oPixData,
  output logic                 oPixValid,
  input  logic                 iPixReady,
  output logic                 oFrameDone
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, NEXT, DRAIN} state_t;
  state_t r_state, w_state;
  logic [CX_W-1:0] r_cx, w_cx;
  logic [CY_W-1:0] r_cy, w_cy;
  logic r_call, w_call, w_fdone, w_push, w_pop, w_last_x, w_last_y, w_space;
  logic r_busy, r_fdone;
  logic [CX_W+CY_W-1:0] r_addr;
  logic [15:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  assign w_last_x = r_cx == CX_W'(H_PIXELS - 1);
  assign w_last_y = r_cy == CY_W'(V_LINES - 1);
  assign w_space = r_cnt < (PW+1)'(FIFO_DEPTH);
  assign oPixValid = r_cnt != '0;
  assign oPixData = oPixValid ? r_mem[r_rp] : '0;
  assign w_pop = oPixValid & iPixReady;
  assign oCall = r_call;
  assign oAddr = r_addr;
  assign oBusy = r_busy;
  assign oFrameDone = r_fdone;
  always_comb begin
    w_state = r_state;
    w_call = r_call;
    w_cx = r_cx;
    w_cy = r_cy;
    w_fdone = 1'b0;
    w_push = 1'b0;
    case (r_state)
      IDLE: w_state = iStart ? REQ : IDLE;
      REQ: begin
        // a call is only raised with FIFO room, so a push never meets a full FIFO
        if (r_call && iDone) begin
          w_push = 1'b1;
          w_call = 1'b0;
          w_state = NEXT;
        end else if (!r_call && w_space) w_call = 1'b1;
      end
      NEXT: begin
        w_state = (w_last_x && w_last_y) ? DRAIN : REQ;
        w_cx = w_last_x ? '0 : r_cx + 1'b1;
        w_cy = (w_last_x && !w_last_y) ? r_cy + 1'b1 : r_cy;
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          w_fdone = 1'b1;
          w_cx = '0;
          w_cy = '0;
`ifdef FB_READER_LOOP_EN
          w_state = REQ;
`else
          w_state = IDLE;
`endif
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_call <= 1'b0;
      r_addr <= '0;
      r_cx <= '0;
      r_cy <= '0;
      r_busy <= 1'b0;
      r_fdone <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_call <= w_call;
      if (w_call && !r_call) r_addr <= {r_cy, r_cx};
      r_cx <= w_cx;
      r_cy <= w_cy;
      r_busy <= w_state != IDLE;
      r_fdone <= w_fdone;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  always_ff @(posedge CLOCK) begin
    if (!RESET && w_push) r_mem[r_wp] <= iData;
  end
endmodule

// File: tb/tb_fb_line_reader.sv
// tb_fb_line_reader: scoreboard bench for fb_line_reader on a 4x2 frame with a 4-deep FIFO
module tb_fb_line_reader;
  logic CLOCK = 0, RESET = 1, iStart = 0, iDone = 0, iPixReady = 0;
  logic [15:0] iData = '0;
  logic oBusy, oCall, oPixValid, oFrameDone;
  logic [23:0] oAddr;
  logic [15:0] oPixData;
  int n_vec = 0, n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] frame[8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0200, 16'h0201, 16'h0202, 16'h0203};
  int resp_delay = 2, done_cnt = 0, fd_cnt = 0, age = 0;
  bit resp_en = 0, spur = 0, last_done = 0, busy_watch = 0, busy_drop = 0;
  logic [23:0] held = '0;

  fb_line_reader #(.H_PIXELS(4), .V_LINES(2), .CX_W(9), .CY_W(15), .FIFO_DEPTH(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .iStart(iStart), .oBusy(oBusy), .oCall(oCall), .oAddr(oAddr),
    .iDone(iDone), .iData(iData), .oPixData(oPixData), .oPixValid(oPixValid),
    .iPixReady(iPixReady), .oFrameDone(oFrameDone)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  // responder: answers each call resp_delay cycles after it rises with its own low address bits
  always @(posedge CLOCK) begin
    #1;
    if (resp_en && last_done) chk("call_gap", oCall, 0);
    last_done = iDone && resp_en;
    iDone = 0;
    if (!resp_en) iDone = spur;
    else if (oCall) begin
      age++;
      if (age == 1) held = oAddr;
      else chk("addr_hold", oAddr, held);
      if (age == resp_delay) begin
        iDone = 1;
        iData = oAddr[15:0];
        done_cnt++;
      end
    end else age = 0;
  end

  // monitor: pops the scoreboard on every accepted pixel
  always @(negedge CLOCK) begin
    if (oFrameDone) fd_cnt++;
    if (busy_watch && !oBusy) busy_drop = 1;
    if (oPixValid && iPixReady) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pix: got %h, expected no pixel", oPixData);
      end else chk("pix", oPixData, exp_q.pop_front());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK);
    #2;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back(frame[i]);
  endtask

  task automatic start();
    iStart = 1;
    tick();
    iStart = 0;
  endtask

  task automatic wait_fd(input int target);
    int c = 0;
    while (fd_cnt < target && c < 500) begin
      tick();
      c++;
    end
    chk("frame_done_wait", fd_cnt, target);
  endtask

  initial begin
    RESET = 1;
    tick(3);
    chk("rst_call", oCall, 0);
    chk("rst_addr", oAddr, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_valid", oPixValid, 0);
    chk("rst_data", oPixData, 0);
    chk("rst_fdone", oFrameDone, 0);
    RESET = 0;
    spur = 1;
    tick(2);
    spur = 0;
    tick(2);
    chk("idle_done_no_push", oPixValid, 0);
    chk("idle_done_no_busy", oBusy, 0);
    resp_en = 1;
`ifdef FB_READER_LOOP_EN
    push_frame();
    push_frame();
    iPixReady = 1;
    start();
    busy_watch = 1;
    wait_fd(2);
    iPixReady = 0;
    busy_watch = 0;
    chk("loop_busy_held", busy_drop, 0);
    chk("loop_stream", exp_q.size(), 0);
    chk("loop_still_busy", oBusy, 1);
    RESET = 1;
    tick();
    RESET = 0;
    chk("loop_reset_busy", oBusy, 0);
`else
    push_frame();
    iPixReady = 1;
    start();
    chk("start_busy", oBusy, 1);
    chk("start_call_low", oCall, 0);
    tick();
    chk("call_rise", oCall, 1);
    chk("first_addr", oAddr, 0);
    wait_fd(1);
    chk("frame_stream", exp_q.size(), 0);
    tick();
    chk("idle_after_frame", oBusy, 0);
    tick(3);
    chk("single_fdone", fd_cnt, 1);
    iPixReady = 0;
    done_cnt = 0;
    push_frame();
    start();
    tick(60);
    chk("bp_calls", done_cnt, 4);
    chk("bp_call_low", oCall, 0);
    chk("bp_full_valid", oPixValid, 1);
    iPixReady = 1;
    wait_fd(2);
    chk("bp_stream", exp_q.size(), 0);
    chk("bp_total_calls", done_cnt, 8);
    resp_delay = 10;
    push_frame();
    start();
    wait_fd(3);
    chk("hold_stream", exp_q.size(), 0);
    resp_delay = 2;
    iPixReady = 0;
    done_cnt = 0;
    start();
    for (int c = 0; c < 100 && done_cnt < 3; c++) tick();
    tick();
    RESET = 1;
    tick();
    chk("mr_call", oCall, 0);
    chk("mr_valid", oPixValid, 0);
    chk("mr_busy", oBusy, 0);
    RESET = 0;
    tick();
    push_frame();
    iPixReady = 1;
    start();
    tick();
    chk("mr_restart_addr", oAddr, 0);
    wait_fd(4);
    chk("mr_stream", exp_q.size(), 0);
`endif
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fb_line_reader.md
Name: fb_line_reader

Overview:
- Framebuffer readback engine: the read-side counterpart of the pixel-fill writer on the SDRAM call/done interface.
- Walks a frame in raster order, issuing one read call per pixel at address {CY,CX}.
- Buffers returned 16-bit RGB565 words in a small FIFO and presents them as a valid/ready pixel stream to downstream logic (display prefetch, checker, DMA).

Parameters:
- H_PIXELS, 320: pixels per line; CX runs 0..H_PIXELS-1.
- V_LINES, 240: lines per frame; CY runs 0..V_LINES-1.
- CX_W, 9: width of CX, the low address field.
- CY_W, 15: width of CY; CX_W+CY_W = 24.
- FIFO_DEPTH, 8: output FIFO entries; power of two, at least 2.

Ports:
- CLOCK  in  1  single system clock (100 MHz main domain).
- RESET  in  1  synchronous, active-high reset.
- iStart  in  1  start one frame read; sampled only in IDLE.
- oBusy  out  1  high in any state other than IDLE.
- oCall  out  1  read request to the SDRAM controller (drives its read-call bit).
- oAddr  out  24  {CY,CX}; stable while oCall is high.
- iDone  in  1  one-cycle read-done pulse from the controller.
- iData  in  16  read data; valid in the iDone cycle.
- oPixData  out  16  FIFO head word.
- oPixValid  out  1  FIFO not empty.
- iPixReady  in  1  downstream accepts the head word.
- oFrameDone  out  1  one-cycle pulse when a frame has been fully read and drained.

Behaviour:
- All outputs are registered except oPixData and oPixValid, which are taken directly from FIFO state.
- Reset values:
  - State = IDLE; oCall = 0; oAddr = 0; CX = CY = 0.
  - FIFO empty, so oPixValid = 0; oPixData = 0.
  - oBusy = 0; oFrameDone = 0.
- RESET asserted mid-operation:
  - Aborts the frame at the next edge; FIFO is flushed.
  - A pending iDone arriving after reset is ignored.
- FSM states:
  - IDLE: on iStart -> REQ; oBusy rises on the same edge. iStart in any other state is ignored.
  - REQ:
    - If FIFO count < FIFO_DEPTH: oCall = 1, oAddr = {CY,CX}.
    - Otherwise oCall stays 0 until space frees.
    - While waiting for iDone: oCall held high and oAddr held constant.
    - On iDone with oCall = 1: push iData, clear oCall at that edge, go to NEXT.
  - NEXT: oCall = 0 for exactly this one cycle, which guarantees the call is low for at least one cycle between requests.
    - If CX = H_PIXELS-1 and CY = V_LINES-1: go to DRAIN.
    - Else if CX = H_PIXELS-1: CX <= 0, CY <= CY+1, go to REQ.
    - Else: CX <= CX+1, go to REQ.
  - DRAIN: wait for the FIFO to empty, then pulse oFrameDone for 1 cycle, clear CX/CY, and go to IDLE.
- Latency:
  - iStart sampled at edge N gives oCall = 1 after edge N+1.
  - iDone at edge M makes the word visible on oPixData/oPixValid after edge M.
- Only one request is outstanding at a time. iDone while oCall = 0 is ignored: no push, no state change.
- FIFO:
  - Pop when oPixValid and iPixReady.
  - Push and pop in the same cycle leaves count unchanged.
  - Push is never attempted when full, because requests are gated by count.
  - Pop when empty is a no-op.
  - Pointers wrap modulo FIFO_DEPTH.
- CX and CY never exceed their maxima. The full address is {CY,CX} with no offset.

Optional Feature:
- Macro: FB_READER_LOOP_EN.
- Defined: after DRAIN pulses oFrameDone, the FSM returns to REQ at (0,0) instead of IDLE, giving continuous frame readback. oBusy stays high; only RESET stops it.
- Undefined: single-shot, as described above. iStart is needed per frame.

Test Plan:
- Reset/idle: assert RESET 3 cycles -> oCall=0, oAddr=0, oBusy=0, oPixValid=0, oFrameDone=0. iDone pulses in IDLE cause no push.
- Full frame, H_PIXELS=4, V_LINES=2:
  - Stimulus: responder returns iData = oAddr[15:0] two cycles after oCall rises; iPixReady=1.
  - Required: stream 0x0000,0x0001,0x0002,0x0003,0x0200,0x0201,0x0202,0x0203.
  - Required: one oFrameDone pulse, then oBusy=0.
- Back-pressure: FIFO_DEPTH=4, iPixReady=0 -> exactly 4 calls complete, then oCall stays 0. Raise iPixReady -> calls resume, and no data is lost or duplicated.
- Handshake hold: delay iDone 10 cycles -> oCall stays 1 and oAddr is unchanged all 10 cycles; oCall is 0 for at least 1 cycle after each iDone.
- Mid-frame reset: RESET after 3 pixels -> next cycle oCall=0 and FIFO is empty. A new iStart re-reads from address 0.
- With FB_READER_LOOP_EN: iStart once -> two consecutive frames of 8 words, two oFrameDone pulses, oBusy never drops.
